// File: rtl/regf_pkg.sv
// rtl/regf_pkg.sv - shared sizing constants and helpers for the scoreboarded register file
package regf_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 3;
  localparam int N_RD_DEF       = 2;
  localparam int BUSY_CNT_W_DEF = ADDR_W_DEF + 1;

  // Number of registers addressed by an ADDR_W-bit address.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Counter must hold the value DEPTH itself, hence one extra bit.
  function automatic int busy_cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/regf_scoreboard.sv
// rtl/regf_scoreboard.sv - per-register busy bits, busy count and double-reserve error pulse
module regf_scoreboard
  import regf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        LD,
  input  logic [ADDR_W-1:0]           DR,
  input  logic                        RSV,
  input  logic [ADDR_W-1:0]           RSV_DR,
  output logic [depth_of(ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]             BUSY_CNT,
  output logic                        RSV_ERR
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CNT_W = busy_cnt_w(ADDR_W);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             same_addr;
  logic             set_new;
  logic             clr_old;

  // Next busy vector, count delta and error; a reserve to the register being written wins.
  always_comb begin
    busy_d    = busy_q;
    same_addr = RSV && LD && (RSV_DR == DR);
    set_new   = RSV && !busy_q[RSV_DR];
    clr_old   = LD && busy_q[DR] && !same_addr;
    err_d     = RSV && busy_q[RSV_DR] && !same_addr;
    if (LD) begin
      busy_d[DR] = 1'b0;
    end
    if (RSV) begin
      busy_d[RSV_DR] = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
  end

  // Scoreboard state register; reset discards any same-cycle LD/RSV.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy     = busy_q;
  assign BUSY_CNT = cnt_q;
  assign RSV_ERR  = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with async read ports and busy scoreboard; optional REGF_BYPASS_EN write-through
module reg_file_sb
  import regf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_RD   = N_RD_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   LD,
  input  logic [ADDR_W-1:0]      DR,
  input  logic [DATA_W-1:0]      D_in,
  input  logic                   RSV,
  input  logic [ADDR_W-1:0]      RSV_DR,
  input  logic [N_RD*ADDR_W-1:0] SA,
  output logic [N_RD*DATA_W-1:0] DATA,
  output logic [N_RD-1:0]        BUSY,
  output logic [ADDR_W:0]        BUSY_CNT,
  output logic                   RSV_ERR
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Storage: clear everything on reset, otherwise one synchronous write per cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (LD) begin
      mem[DR] <= D_in;
    end
  end

  regf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .CLK      (CLK),
    .RESET    (RESET),
    .LD       (LD),
    .DR       (DR),
    .RSV      (RSV),
    .RSV_DR   (RSV_DR),
    .busy     (busy),
    .BUSY_CNT (BUSY_CNT),
    .RSV_ERR  (RSV_ERR)
  );

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = SA[k*ADDR_W +: ADDR_W];
`ifdef REGF_BYPASS_EN
    // Write-back data arriving this cycle is forwarded; a write that reset ignores is not.
    logic hit;
    assign hit = LD && !RESET && (addr == DR);
    assign DATA[k*DATA_W +: DATA_W] = hit ? D_in : mem[addr];
    assign BUSY[k]                  = hit ? 1'b0 : busy[addr];
`else
    assign DATA[k*DATA_W +: DATA_W] = mem[addr];
    assign BUSY[k]                  = busy[addr];
`endif
  end

endmodule
